// File: rtl/dmem_responder.sv
// dmem_responder: single-cycle data-memory slave (word RAM + MMIO timer/status page); timer built only with DMEM_TIMER_EN
module dmem_responder #(
  parameter int         ADDR_W    = 8,
  parameter logic [3:0] MMIO_PAGE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        misalign_o,
  output logic        timer_irq_o
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [1:0]        off;
  logic              ram_hit, mmio_hit, ram_wr, mmio_wr, st_wr;
  logic              mis_q, mis_d;
  logic [31:0]       mtime_rd, cmp_rd, mmio_rd;
  logic              en_rd, irq_rd;
  assign idx        = addr[ADDR_W+1:2];
  assign off        = addr[3:2];
  assign misalign_o = |addr[1:0];
  assign ram_hit    = (addr[31:28] == 4'h0) && (addr[27:ADDR_W+2] == '0);
  assign mmio_hit   = (addr[31:28] == MMIO_PAGE) && (addr[27:4] == '0);
  assign ram_wr     = mem_wr && ram_hit && !misalign_o;
  assign mmio_wr    = mem_wr && mmio_hit && !misalign_o;
  assign st_wr      = mmio_wr && (off == 2'd3);
  // RAM store; contents survive reset, but a store issued while reset is held is dropped
  always_ff @(posedge clk) begin
    if (rst && ram_wr) mem_q[idx] <= wr_data;
  end
  // Misalign sticky: a misaligned store sets it, W1C of bit1 clears it, set beats clear
  always_comb begin
    mis_d = (mem_wr && misalign_o) ? 1'b1 : (st_wr && wr_data[1]) ? 1'b0 : mis_q;
  end
  // Status register state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mis_q <= 1'b0;
    else      mis_q <= mis_d;
  end
`ifdef DMEM_TIMER_EN
  logic [31:0] mtime_q, mtime_d, cmp_q, cmp_d;
  logic        en_q, en_d, irq_q, irq_d;
  // Timer next state: store beats increment; compare uses pre-increment MTIME; set beats W1C
  always_comb begin
    mtime_d = (mmio_wr && off == 2'd0) ? wr_data : en_q ? mtime_q + 32'd1 : mtime_q;
    cmp_d   = (mmio_wr && off == 2'd1) ? wr_data : cmp_q;
    en_d    = (mmio_wr && off == 2'd2) ? wr_data[0] : en_q;
    irq_d   = (en_q && mtime_q == cmp_q) ? 1'b1 : (st_wr && wr_data[0]) ? 1'b0 : irq_q;
  end
  // Timer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime_q <= '0;
      cmp_q   <= '1;
      en_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      irq_q   <= irq_d;
    end
  end
  assign mtime_rd    = mtime_q;
  assign cmp_rd      = cmp_q;
  assign en_rd       = en_q;
  assign irq_rd      = irq_q;
  assign timer_irq_o = irq_q;
`else
  assign mtime_rd    = '0;
  assign cmp_rd      = '0;
  assign en_rd       = 1'b0;
  assign irq_rd      = 1'b0;
  assign timer_irq_o = 1'b0;
`endif
  // Zero-latency read mux; misaligned and unmapped accesses read 0
  always_comb begin
    mmio_rd = (off == 2'd0) ? mtime_rd :
              (off == 2'd1) ? cmp_rd :
              (off == 2'd2) ? {31'd0, en_rd} : {30'd0, mis_q, irq_rd};
    rd_data = misalign_o ? 32'd0 : ram_hit ? mem_q[idx] : mmio_hit ? mmio_rd : 32'd0;
  end
endmodule
